// File: rtl/uart_bus_master.sv
// UART-driven single-word bus initiator. Receives 8N1 command frames,
// issues MemRead/MemWrite on the CPU system bus and replies over Tx_Serial.
module uart_bus_master #(
   parameter int CLKS_PER_BIT = 10417
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        Rx_Serial,
   input  logic [31:0] read_data,
   output logic        Tx_Serial,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] address,
   output logic [31:0] write_data,
   output logic        busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] ACK       = 8'h06;
   localparam logic [7:0] NAK       = 8'h15;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {S_IDLE, S_GET_ADDR, S_GET_DATA, S_WRITE, S_READ, S_SEND} state_t;

   logic rx_meta_q, rx_sync_q;

   rx_state_t      rx_state_q, rx_state_d;
   logic [CW-1:0]  rx_cnt_q, rx_cnt_d;
   logic [2:0]     rx_bit_q, rx_bit_d;
   logic [7:0]     rx_shift_q, rx_shift_d;
   logic           rx_valid, rx_err;

   tx_state_t      tx_state_q, tx_state_d;
   logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
   logic [2:0]     tx_bit_q, tx_bit_d;
   logic [7:0]     tx_shift_q, tx_shift_d;
   logic           tx_req, tx_ack, tx_last;
   logic [7:0]     tx_byte;

   state_t         state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic           is_write_q, is_write_d;
   logic [31:0]    address_q, address_d;
   logic [31:0]    write_data_q, write_data_d;
   logic [23:0]    reply_q, reply_d;
   logic [1:0]     left_q, left_d;
   logic           nak;

   // Two-flop synchronizer for the asynchronous receive line
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= Rx_Serial;
         rx_sync_q <= rx_meta_q;
      end
   end

   // Receiver: glitch-checked start bit, mid-bit sampling, stop-bit framing check
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_valid   = 1'b0;
      rx_err     = 1'b0;
      case (rx_state_q)
         RX_IDLE: if (!rx_sync_q) begin
            rx_state_d = RX_START;
            rx_cnt_d   = '0;
         end
         RX_START: if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
         end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
         end
         RX_DATA: if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
         end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
         end
         RX_STOP: if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d   = '0;
            rx_state_d = RX_IDLE;
            rx_valid   = rx_sync_q;
            rx_err     = !rx_sync_q;
         end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
         end
         default: rx_state_d = RX_IDLE;
      endcase
      if (!en) begin
         rx_state_d = RX_IDLE;
         rx_cnt_d   = '0;
         rx_valid   = 1'b0;
         rx_err     = 1'b0;
      end
   end

   // Transmitter handshake: a new byte is taken while idle or in the last stop-bit cycle
   assign tx_last = (tx_state_q == TX_STOP) && (tx_cnt_q == BIT_LAST);
   assign tx_ack  = tx_req && ((tx_state_q == TX_IDLE) || tx_last);

   // Transmitter next state; loading at the last stop cycle keeps reply bytes back to back
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      case (tx_state_q)
         TX_IDLE: ;
         TX_START: if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_state_d = TX_DATA;
         end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
         end
         TX_DATA: if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d   = '0;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
         end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
         end
         TX_STOP: if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d   = '0;
            tx_state_d = TX_IDLE;
         end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
         end
         default: tx_state_d = TX_IDLE;
      endcase
      if (tx_ack) begin
         tx_state_d = TX_START;
         tx_cnt_d   = '0;
         tx_shift_d = tx_byte;
      end
      if (!en) begin
         tx_state_d = TX_IDLE;
         tx_cnt_d   = '0;
      end
   end

   // Serial line level from the transmitter state
   always_comb begin
      case (tx_state_q)
         TX_START: Tx_Serial = 1'b0;
         TX_DATA:  Tx_Serial = tx_shift_q[0];
         default:  Tx_Serial = 1'b1;
      endcase
   end

   // Main FSM: frame parsing, bus strobes, reply queueing.
   // The first reply byte is handed to the transmitter from WRITE/READ (or on the NAK
   // decision) so its start bit begins the following cycle.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      is_write_d   = is_write_q;
      address_d    = address_q;
      write_data_d = write_data_q;
      reply_d      = reply_q;
      left_d       = left_q;
      tx_req       = 1'b0;
      tx_byte      = '0;
      nak          = 1'b0;
      case (state_q)
         S_IDLE: if (rx_valid) begin
            if (rx_shift_q == CMD_WRITE || rx_shift_q == CMD_READ) begin
               state_d    = S_GET_ADDR;
               cnt_d      = '0;
               is_write_d = (rx_shift_q == CMD_WRITE);
            end else begin
               nak = 1'b1;
            end
         end else if (rx_err) begin
            nak = 1'b1;
         end
         S_GET_ADDR: if (rx_err) begin
            nak = 1'b1;
         end else if (rx_valid) begin
            address_d = {address_q[23:0], rx_shift_q};
            cnt_d     = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = is_write_q ? S_GET_DATA : S_READ;
         end
         S_GET_DATA: if (rx_err) begin
            nak = 1'b1;
         end else if (rx_valid) begin
            write_data_d = {write_data_q[23:0], rx_shift_q};
            cnt_d        = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = S_WRITE;
         end
         S_WRITE: begin
            tx_req  = 1'b1;
            tx_byte = ACK;
            left_d  = '0;
            state_d = S_SEND;
         end
         S_READ: begin
            tx_req  = 1'b1;
            tx_byte = read_data[31:24];
            reply_d = read_data[23:0];
            left_d  = 2'd3;
            state_d = S_SEND;
         end
         S_SEND: if (left_q != '0) begin
            tx_req  = 1'b1;
            tx_byte = reply_q[23:16];
            if (tx_ack) begin
               reply_d = {reply_q[15:0], 8'h00};
               left_d  = left_q - 2'd1;
            end
         end else if (tx_last) begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (nak) begin
         tx_req  = 1'b1;
         tx_byte = NAK;
         left_d  = '0;
         state_d = S_SEND;
      end
      if (!en) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         left_d  = '0;
         tx_req  = 1'b0;
      end
   end

   // State registers for receiver, transmitter and main FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state_q   <= RX_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         tx_state_q   <= TX_IDLE;
         tx_cnt_q     <= '0;
         tx_bit_q     <= '0;
         tx_shift_q   <= '0;
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         is_write_q   <= 1'b0;
         address_q    <= '0;
         write_data_q <= '0;
         reply_q      <= '0;
         left_q       <= '0;
      end else begin
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         tx_state_q   <= tx_state_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_shift_q   <= tx_shift_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         is_write_q   <= is_write_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
         reply_q      <= reply_d;
         left_q       <= left_d;
      end
   end

   assign MemWrite   = (state_q == S_WRITE) && en;
   assign MemRead    = (state_q == S_READ) && en;
   assign address    = address_q;
   assign write_data = write_data_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: stimulus pushes expected bus/serial
// events, a negedge monitor decodes Tx_Serial and bus strobes and compares.
module tb_uart_bus_master;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b1;
   logic        Rx_Serial = 1'b1;
   logic [31:0] read_data;
   logic        Tx_Serial, MemRead, MemWrite, busy;
   logic [31:0] address, write_data;

   uart_bus_master #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .Rx_Serial  (Rx_Serial),
      .read_data  (read_data),
      .Tx_Serial  (Tx_Serial),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .address    (address),
      .write_data (write_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus memory model
   assign read_data = (address == 32'h0000_0010) ? 32'hDEAD_BEEF :
                      (address == 32'h0000_0000) ? 32'h1234_5678 : 32'hBAD0_BAD0;

   typedef struct {
      int          kind;   // 0 write strobe, 1 read strobe, 2 tx byte
      logic [31:0] addr;
      logic [31:0] data;
      int          dur;    // cycles from strobe to busy low
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  fails  = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void push(input int kind, input logic [31:0] a, input logic [31:0] d, input int dur);
      ev_t e;
      e.kind = kind; e.addr = a; e.data = d; e.dur = dur;
      exp_q.push_back(e);
   endfunction

   function automatic void push_bytes(input logic [31:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) push(2, '0, (w >> (8 * i)) & 32'hFF, 0);
   endfunction

   // Monitor: bus strobes, reply duration and serial decode
   int          strobe_cyc = 0;
   int          pending_dur = 0;
   bit          pending = 0;
   logic        prev_busy = 1'b0;
   bit          dec_active = 0;
   int          dcnt = 0;
   logic [7:0]  dbyte = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            dec_active = 0;
            pending    = 0;
            prev_busy  = 1'b0;
         end else begin
            if (MemWrite || MemRead) begin
               chk("strobe_exclusive", {63'd0, MemWrite & MemRead}, 64'd0);
               if (exp_q.size() == 0) begin
                  chk("unexpected_strobe", 64'd1, 64'd0);
               end else begin
                  ev_t e;
                  e = exp_q.pop_front();
                  chk("bus_kind", MemWrite ? 64'd0 : 64'd1, e.kind);
                  chk("bus_addr", address, e.addr);
                  if (MemWrite) chk("bus_wdata", write_data, e.data);
                  pending     = 1;
                  pending_dur = e.dur;
                  strobe_cyc  = cyc;
               end
            end
            if (prev_busy && !busy && pending) begin
               chk("reply_cycles", cyc - strobe_cyc, pending_dur);
               pending = 0;
            end
            prev_busy = busy;
            if (!dec_active) begin
               if (Tx_Serial == 1'b0) begin
                  dec_active = 1;
                  dcnt       = 0;
               end
            end else begin
               dcnt++;
            end
            if (dec_active && (dcnt % CPB) == CPB / 2) begin
               int k;
               k = dcnt / CPB;
               if (k == 0) begin
                  chk("tx_start_bit", {63'd0, Tx_Serial}, 64'd0);
               end else if (k <= 8) begin
                  dbyte[k-1] = Tx_Serial;
               end else begin
                  chk("tx_stop_bit", {63'd0, Tx_Serial}, 64'd1);
                  dec_active = 0;
                  if (exp_q.size() == 0) begin
                     chk("unexpected_tx_byte", {56'd0, dbyte}, 64'hFFFF);
                  end else begin
                     ev_t e;
                     e = exp_q.pop_front();
                     chk("tx_kind", 64'd2, e.kind);
                     chk("tx_byte", {56'd0, dbyte}, {56'd0, e.data[7:0]});
                  end
               end
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      Rx_Serial = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         Rx_Serial = b[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      Rx_Serial = stop;
      repeat (CPB) @(posedge clk);
      #1;
      Rx_Serial = 1'b1;
   endtask

   task automatic send_frame(input logic [71:0] f, input int n);
      for (int i = n - 1; i >= 0; i--) send_byte(f[8*i +: 8], 1'b1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      repeat (3) @(posedge clk);
      while (busy && n < 2000) begin
         @(posedge clk);
         n++;
      end
      if (busy) chk({name, "_timeout"}, 64'd1, 64'd0);
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      chk("rst_tx",       {63'd0, Tx_Serial}, 64'd1);
      chk("rst_memread",  {63'd0, MemRead},   64'd0);
      chk("rst_memwrite", {63'd0, MemWrite},  64'd0);
      chk("rst_address",  address,            64'd0);
      chk("rst_wdata",    write_data,         64'd0);
      chk("rst_busy",     {63'd0, busy},      64'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // Write frame
      push(0, 32'h4000_000C, 32'h0000_00A5, 41);
      push_bytes(32'h06, 1);
      send_frame(72'h57_40_00_00_0C_00_00_00_A5, 9);
      wait_idle("write");

      // Read frame
      push(1, 32'h0000_0010, '0, 161);
      push_bytes(32'hDEAD_BEEF, 4);
      send_frame(72'h52_00_00_00_10, 5);
      wait_idle("read");

      // Invalid command
      push_bytes(32'h15, 1);
      send_frame(72'h33, 1);
      wait_idle("invalid_cmd");

      // Framing error on the third byte of a write, then a good write
      push_bytes(32'h15, 1);
      send_byte(8'h57, 1'b1);
      send_byte(8'h40, 1'b1);
      send_byte(8'h00, 1'b0);
      wait_idle("framing");
      push(0, 32'h0000_0020, 32'h1122_3344, 41);
      push_bytes(32'h06, 1);
      send_frame(72'h57_00_00_00_20_11_22_33_44, 9);
      wait_idle("after_framing");

      // Glitch shorter than half a bit
      Rx_Serial = 1'b0;
      @(posedge clk);
      #1 Rx_Serial = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      chk("glitch_busy", {63'd0, busy}, 64'd0);

      // Reset during the second reply byte of a read
      push(1, 32'h0000_0010, '0, 161);
      push_bytes(32'hDEAD_BEEF, 4);
      send_frame(72'h52_00_00_00_10, 5);
      repeat (60) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("midrst_tx",       {63'd0, Tx_Serial}, 64'd1);
      chk("midrst_busy",     {63'd0, busy},      64'd0);
      chk("midrst_memread",  {63'd0, MemRead},   64'd0);
      chk("midrst_memwrite", {63'd0, MemWrite},  64'd0);
      chk("midrst_address",  address,            64'd0);
      repeat (3) @(posedge clk);
      #1;
      exp_q.delete();
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      push(0, 32'h0000_0030, 32'hCAFE_F00D, 41);
      push_bytes(32'h06, 1);
      send_frame(72'h57_00_00_00_30_CA_FE_F0_0D, 9);
      wait_idle("after_reset");

      // en dropped after three address bytes
      send_frame(72'h57_AA_BB_CC, 4);
      @(posedge clk);
      #1 en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("en_low_busy", {63'd0, busy}, 64'd0);
      chk("en_low_tx",   {63'd0, Tx_Serial}, 64'd1);
      chk("en_addr_hold", address, 64'h30AA_BBCC);
      en = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      push(1, 32'h0000_0000, '0, 161);
      push_bytes(32'h1234_5678, 4);
      send_frame(72'h52_00_00_00_00, 5);
      wait_idle("en_read");

      chk("queue_empty", exp_q.size(), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
